// File: rtl/rip_mem_subsys.sv
// rtl/rip_mem_subsys.sv - dual-port (fetch + data) byte-addressable memory with per-port latency pipelines
// Optional feature macro: RIP_MEM_MISALIGN_TRAP_EN (misaligned accesses trap instead of aligning down)

module rip_mem_pipe #(
   parameter int W   = 32,
   parameter int LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid_i,
   output logic         req_ready_o,
   input  logic [W-1:0] req_data_i,
   input  logic         req_err_i,
   output logic         resp_valid_o,
   input  logic         resp_ready_i,
   output logic [W-1:0] resp_data_o,
   output logic         resp_err_o
);
   logic [LAT-1:0] v_q, v_d;
   logic [LAT-1:0] e_q, e_d;
   logic [W-1:0]   d_q [LAT];
   logic [W-1:0]   d_d [LAT];
   logic           adv;

   // The whole pipe moves as one unit whenever the output stage is free or being consumed
   assign adv          = ~v_q[LAT-1] | resp_ready_i;
   assign req_ready_o  = adv;
   assign resp_valid_o = v_q[LAT-1];
   assign resp_data_o  = d_q[LAT-1];
   assign resp_err_o   = e_q[LAT-1];

   // Next-state shift; empty stages carry zeros so idle outputs read as 0
   always_comb begin
      v_d = v_q;
      e_d = e_q;
      d_d = d_q;
      if (adv) begin
         v_d[0] = req_valid_i;
         e_d[0] = req_valid_i & req_err_i;
         d_d[0] = req_valid_i ? req_data_i : '0;
         for (int i = 1; i < LAT; i++) begin
            v_d[i] = v_q[i-1];
            e_d[i] = e_q[i-1];
            d_d[i] = d_q[i-1];
         end
      end
   end

   // Stage registers; reset drops anything in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         e_q <= '0;
         for (int i = 0; i < LAT; i++) d_q[i] <= '0;
      end else begin
         v_q <= v_d;
         e_q <= e_d;
         for (int i = 0; i < LAT; i++) d_q[i] <= d_d[i];
      end
   end
endmodule

module rip_mem_subsys #(
   parameter int NUM_COL      = 4,
   parameter int ADDR_WIDTH   = 20,
   parameter int READ_LATENCY = 1,
   parameter     INIT_FILE    = ""
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_req_valid,
   output logic                 if_req_ready,
   input  logic [NUM_COL*8-1:0] if_addr,
   output logic                 if_resp_valid,
   input  logic                 if_resp_ready,
   output logic [NUM_COL*8-1:0] if_rdata,
   output logic                 if_err,
   input  logic                 ma_req_valid,
   output logic                 ma_req_ready,
   input  logic                 ma_we,
   input  logic [1:0]           ma_size,
   input  logic                 ma_unsigned,
   input  logic [NUM_COL*8-1:0] ma_addr,
   input  logic [NUM_COL*8-1:0] ma_wdata,
   output logic                 ma_resp_valid,
   input  logic                 ma_resp_ready,
   output logic [NUM_COL*8-1:0] ma_rdata,
   output logic                 ma_err
);
   localparam int DW    = NUM_COL * 8;
   localparam int OFS   = $clog2(NUM_COL);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DW-1:0]         mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] if_idx, ma_idx;
   logic [DW-1:0]         if_rdata_c, ma_rdata_c;
   logic                  if_err_c, ma_err_c, ma_illegal, ma_wr, ma_sgn;
   logic [OFS-1:0]        ma_ofs, size_mask;
   logic [NUM_COL-1:0]    ma_be;
   logic [DW-1:0]         ma_wsh, ma_rsh, ma_ext;
   int                    ma_nb;
   logic                  unused_addr;

   // Address bits above the array size alias by design; fold them so they are visibly consumed
   assign unused_addr = ^{if_addr, ma_addr};

   assign if_idx = if_addr[ADDR_WIDTH+OFS-1:OFS];
   assign ma_idx = ma_addr[ADDR_WIDTH+OFS-1:OFS];

`ifdef RIP_MEM_MISALIGN_TRAP_EN
   assign if_err_c   = if_addr[OFS-1:0] != '0;
   assign if_rdata_c = if_err_c ? '0 : mem_q[if_idx];
`else
   assign if_err_c   = 1'b0;
   assign if_rdata_c = mem_q[if_idx];
`endif

   // Data-port decode: legality, lane selection, store alignment and load extension
   always_comb begin
      ma_illegal = (ma_size == 2'd3) && (NUM_COL == 4);
      size_mask  = OFS'((1 << ma_size) - 1);
`ifdef RIP_MEM_MISALIGN_TRAP_EN
      ma_ofs   = ma_addr[OFS-1:0];
      ma_err_c = ma_illegal | ((ma_addr[OFS-1:0] & size_mask) != '0);
`else
      ma_ofs   = ma_addr[OFS-1:0] & ~size_mask;
      ma_err_c = ma_illegal;
`endif
      ma_nb = 1 << ma_size;
      for (int j = 0; j < NUM_COL; j++)
         ma_be[j] = (j >= int'(ma_ofs)) && (j < int'(ma_ofs) + ma_nb);
      ma_wsh = ma_wdata << (8 * ma_ofs);
      ma_rsh = mem_q[ma_idx] >> (8 * ma_ofs);
      case (ma_size)
         2'd0:    ma_sgn = ma_rsh[7];
         2'd1:    ma_sgn = ma_rsh[15];
         2'd2:    ma_sgn = ma_rsh[31];
         default: ma_sgn = ma_rsh[DW-1];
      endcase
      for (int k = 0; k < DW; k++)
         ma_ext[k] = (k < ma_nb * 8) ? ma_rsh[k] : (~ma_unsigned & ma_sgn);
      ma_rdata_c = (ma_err_c | ma_we) ? '0 : ma_ext;
   end

   assign ma_wr = ma_req_valid & ma_req_ready & ma_we & ~ma_err_c & ~rst;

   // Byte-lane writes land at the end of the acceptance cycle; contents survive reset
   always_ff @(posedge clk) begin
      if (ma_wr) begin
         for (int j = 0; j < NUM_COL; j++)
            if (ma_be[j]) mem_q[ma_idx][8*j +: 8] <= ma_wsh[8*j +: 8];
      end
   end

   rip_mem_pipe #(.W(DW), .LAT(READ_LATENCY)) u_if_pipe (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (if_req_valid),
      .req_ready_o  (if_req_ready),
      .req_data_i   (if_rdata_c),
      .req_err_i    (if_err_c),
      .resp_valid_o (if_resp_valid),
      .resp_ready_i (if_resp_ready),
      .resp_data_o  (if_rdata),
      .resp_err_o   (if_err)
   );

   rip_mem_pipe #(.W(DW), .LAT(READ_LATENCY)) u_ma_pipe (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (ma_req_valid),
      .req_ready_o  (ma_req_ready),
      .req_data_i   (ma_rdata_c),
      .req_err_i    (ma_err_c),
      .resp_valid_o (ma_resp_valid),
      .resp_ready_i (ma_resp_ready),
      .resp_data_o  (ma_rdata),
      .resp_err_o   (ma_err)
   );
endmodule

// File: tb/tb_rip_mem_subsys.sv
// tb/tb_rip_mem_subsys.sv - directed table-driven bench for rip_mem_subsys
module tb_rip_mem_subsys;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // a: NUM_COL=4 LAT=1, b: NUM_COL=4 LAT=3, c: NUM_COL=8 LAT=1
   logic        a_if_req_valid, a_if_req_ready, a_if_resp_valid, a_if_resp_ready, a_if_err;
   logic [31:0] a_if_addr, a_if_rdata;
   logic        a_ma_req_valid, a_ma_req_ready, a_ma_we, a_ma_unsigned, a_ma_resp_valid, a_ma_resp_ready, a_ma_err;
   logic [1:0]  a_ma_size;
   logic [31:0] a_ma_addr, a_ma_wdata, a_ma_rdata;

   logic        b_if_req_valid, b_if_req_ready, b_if_resp_valid, b_if_resp_ready, b_if_err;
   logic [31:0] b_if_addr, b_if_rdata;
   logic        b_ma_req_valid, b_ma_req_ready, b_ma_we, b_ma_unsigned, b_ma_resp_valid, b_ma_resp_ready, b_ma_err;
   logic [1:0]  b_ma_size;
   logic [31:0] b_ma_addr, b_ma_wdata, b_ma_rdata;

   logic        c_if_req_valid, c_if_req_ready, c_if_resp_valid, c_if_resp_ready, c_if_err;
   logic [63:0] c_if_addr, c_if_rdata;
   logic        c_ma_req_valid, c_ma_req_ready, c_ma_we, c_ma_unsigned, c_ma_resp_valid, c_ma_resp_ready, c_ma_err;
   logic [1:0]  c_ma_size;
   logic [63:0] c_ma_addr, c_ma_wdata, c_ma_rdata;

   rip_mem_subsys u_a (
      .clk(clk), .rst(rst),
      .if_req_valid(a_if_req_valid), .if_req_ready(a_if_req_ready), .if_addr(a_if_addr),
      .if_resp_valid(a_if_resp_valid), .if_resp_ready(a_if_resp_ready), .if_rdata(a_if_rdata), .if_err(a_if_err),
      .ma_req_valid(a_ma_req_valid), .ma_req_ready(a_ma_req_ready), .ma_we(a_ma_we), .ma_size(a_ma_size),
      .ma_unsigned(a_ma_unsigned), .ma_addr(a_ma_addr), .ma_wdata(a_ma_wdata),
      .ma_resp_valid(a_ma_resp_valid), .ma_resp_ready(a_ma_resp_ready), .ma_rdata(a_ma_rdata), .ma_err(a_ma_err)
   );

   rip_mem_subsys #(.NUM_COL(4), .ADDR_WIDTH(8), .READ_LATENCY(3)) u_b (
      .clk(clk), .rst(rst),
      .if_req_valid(b_if_req_valid), .if_req_ready(b_if_req_ready), .if_addr(b_if_addr),
      .if_resp_valid(b_if_resp_valid), .if_resp_ready(b_if_resp_ready), .if_rdata(b_if_rdata), .if_err(b_if_err),
      .ma_req_valid(b_ma_req_valid), .ma_req_ready(b_ma_req_ready), .ma_we(b_ma_we), .ma_size(b_ma_size),
      .ma_unsigned(b_ma_unsigned), .ma_addr(b_ma_addr), .ma_wdata(b_ma_wdata),
      .ma_resp_valid(b_ma_resp_valid), .ma_resp_ready(b_ma_resp_ready), .ma_rdata(b_ma_rdata), .ma_err(b_ma_err)
   );

   rip_mem_subsys #(.NUM_COL(8), .ADDR_WIDTH(8), .READ_LATENCY(1)) u_c (
      .clk(clk), .rst(rst),
      .if_req_valid(c_if_req_valid), .if_req_ready(c_if_req_ready), .if_addr(c_if_addr),
      .if_resp_valid(c_if_resp_valid), .if_resp_ready(c_if_resp_ready), .if_rdata(c_if_rdata), .if_err(c_if_err),
      .ma_req_valid(c_ma_req_valid), .ma_req_ready(c_ma_req_ready), .ma_we(c_ma_we), .ma_size(c_ma_size),
      .ma_unsigned(c_ma_unsigned), .ma_addr(c_ma_addr), .ma_wdata(c_ma_wdata),
      .ma_resp_valid(c_ma_resp_valid), .ma_resp_ready(c_ma_resp_ready), .ma_rdata(c_ma_rdata), .ma_err(c_ma_err)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vt [$];

   task automatic add(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] ad,
                      input logic [31:0] wd, input logic [31:0] rd, input logic er);
      vec_t v;
      v.we = we; v.size = sz; v.uns = uns; v.addr = ad; v.wdata = wd; v.exp_rdata = rd; v.exp_err = er;
      vt.push_back(v);
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic c_tx(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] ad, input logic [63:0] wd, input logic [63:0] exp);
      c_ma_we = we; c_ma_size = sz; c_ma_unsigned = uns; c_ma_addr = ad; c_ma_wdata = wd;
      c_ma_req_valid = 1'b1;
      @(negedge clk);
      c_ma_req_valid = 1'b0;
      chk1({nm, " valid"}, c_ma_resp_valid, 1'b1);
      chk64({nm, " rdata"}, c_ma_rdata, exp);
      chk1({nm, " err"}, c_ma_err, 1'b0);
   endtask

   task automatic b_issue(input logic we, input logic [31:0] ad, input logic [31:0] wd);
      b_ma_we = we; b_ma_size = 2'd2; b_ma_unsigned = 1'b0; b_ma_addr = ad; b_ma_wdata = wd;
      b_ma_req_valid = 1'b1;
   endtask

   initial begin
      {a_if_req_valid, a_ma_req_valid, a_ma_we, a_ma_unsigned} = '0;
      {b_if_req_valid, b_ma_req_valid, b_ma_we, b_ma_unsigned} = '0;
      {c_if_req_valid, c_ma_req_valid, c_ma_we, c_ma_unsigned} = '0;
      a_if_addr = '0; a_ma_addr = '0; a_ma_wdata = '0; a_ma_size = '0;
      b_if_addr = '0; b_ma_addr = '0; b_ma_wdata = '0; b_ma_size = '0;
      c_if_addr = '0; c_ma_addr = '0; c_ma_wdata = '0; c_ma_size = '0;
      {a_if_resp_ready, a_ma_resp_ready, b_if_resp_ready, b_ma_resp_ready, c_if_resp_ready, c_ma_resp_ready} = '1;

      // reset state
      repeat (2) @(negedge clk);
      chk1("rst a_ma_resp_valid", a_ma_resp_valid, 1'b0);
      chk1("rst a_if_resp_valid", a_if_resp_valid, 1'b0);
      chk32("rst a_ma_rdata", a_ma_rdata, 32'h0);
      chk1("rst a_ma_err", a_ma_err, 1'b0);
      chk1("rst b_ma_resp_valid", b_ma_resp_valid, 1'b0);
      chk64("rst c_ma_rdata", c_ma_rdata, 64'h0);
      rst = 1'b0;
      chk1("post-rst a_ma_req_ready", a_ma_req_ready, 1'b1);
      chk1("post-rst a_if_req_ready", a_if_req_ready, 1'b1);
      @(negedge clk);
      chk1("post-rst a_ma_resp_valid", a_ma_resp_valid, 1'b0);

      // data-port vectors on the LAT=1 RV32 instance
      add(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
      add(0, 2'd0, 0, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
      add(0, 2'd0, 1, 32'h13, 32'h0, 32'h000000DE, 0);
      add(0, 2'd1, 0, 32'h12, 32'h0, 32'hFFFFDEAD, 0);
      add(0, 2'd1, 1, 32'h10, 32'h0, 32'h0000BEEF, 0);
      add(0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
      add(1, 2'd0, 0, 32'h11, 32'hFFFFFF5A, 32'h0, 0);
      add(0, 2'd2, 0, 32'h10, 32'h0, 32'hDEAD5AEF, 0);
      add(0, 2'd0, 0, 32'h10, 32'h0, 32'hFFFFFFEF, 0);
      add(1, 2'd2, 0, 32'h18, 32'hCAFEF00D, 32'h0, 0);
      add(1, 2'd3, 0, 32'h18, 32'h11111111, 32'h0, 1);
      add(0, 2'd3, 0, 32'h18, 32'h0, 32'h0, 1);
      add(0, 2'd2, 0, 32'h18, 32'h0, 32'hCAFEF00D, 0);
      add(1, 2'd2, 0, 32'h00400020, 32'h13572468, 32'h0, 0);
      add(0, 2'd2, 0, 32'h20, 32'h0, 32'h13572468, 0);
`ifdef RIP_MEM_MISALIGN_TRAP_EN
      add(1, 2'd1, 0, 32'h21, 32'hABCD, 32'h0, 1);
      add(0, 2'd1, 1, 32'h20, 32'h0, 32'h00002468, 0);
      add(0, 2'd2, 0, 32'h21, 32'h0, 32'h0, 1);
`else
      add(1, 2'd1, 0, 32'h21, 32'hABCD, 32'h0, 0);
      add(0, 2'd1, 1, 32'h20, 32'h0, 32'h0000ABCD, 0);
      add(0, 2'd2, 0, 32'h21, 32'h0, 32'h1357ABCD, 0);
`endif
      add(1, 2'd2, 0, 32'h40, 32'h0, 32'h0, 0);
      add(1, 2'd1, 0, 32'h4A, 32'h8001, 32'h0, 0);
      add(0, 2'd1, 0, 32'h4A, 32'h0, 32'hFFFF8001, 0);
      add(0, 2'd1, 1, 32'h4A, 32'h0, 32'h00008001, 0);

      for (int i = 0; i < vt.size(); i++) begin
         a_ma_we = vt[i].we; a_ma_size = vt[i].size; a_ma_unsigned = vt[i].uns;
         a_ma_addr = vt[i].addr; a_ma_wdata = vt[i].wdata; a_ma_req_valid = 1'b1;
         @(negedge clk);
         a_ma_req_valid = 1'b0;
         chk1($sformatf("vec%0d valid", i), a_ma_resp_valid, 1'b1);
         chk32($sformatf("vec%0d rdata", i), a_ma_rdata, vt[i].exp_rdata);
         chk1($sformatf("vec%0d err", i), a_ma_err, vt[i].exp_err);
      end

      // same-cycle store and fetch of one word: fetch sees the old value, the next fetch the new one
      a_ma_we = 1'b1; a_ma_size = 2'd2; a_ma_unsigned = 1'b0; a_ma_addr = 32'h40; a_ma_wdata = 32'h12345678;
      a_ma_req_valid = 1'b1; a_if_addr = 32'h40; a_if_req_valid = 1'b1;
      @(negedge clk);
      a_ma_req_valid = 1'b0;
      chk1("rf if valid", a_if_resp_valid, 1'b1);
      chk32("rf if old", a_if_rdata, 32'h0);
      chk1("rf ma valid", a_ma_resp_valid, 1'b1);
      @(negedge clk);
      chk1("rf if2 valid", a_if_resp_valid, 1'b1);
      chk32("rf if new", a_if_rdata, 32'h12345678);
      a_if_addr = 32'h42;
      @(negedge clk);
      a_if_req_valid = 1'b0;
`ifdef RIP_MEM_MISALIGN_TRAP_EN
      chk32("if mis rdata", a_if_rdata, 32'h0);
      chk1("if mis err", a_if_err, 1'b1);
`else
      chk32("if mis rdata", a_if_rdata, 32'h12345678);
      chk1("if mis err", a_if_err, 1'b0);
`endif

      // load accepted the cycle right after a store to the same word
      a_ma_we = 1'b1; a_ma_addr = 32'h44; a_ma_wdata = 32'h0BADF00D; a_ma_req_valid = 1'b1;
      @(negedge clk);
      a_ma_we = 1'b0;
      chk32("raw store resp", a_ma_rdata, 32'h0);
      @(negedge clk);
      a_ma_req_valid = 1'b0;
      chk32("raw load", a_ma_rdata, 32'h0BADF00D);
      @(negedge clk);
      chk1("drained ma", a_ma_resp_valid, 1'b0);
      chk1("drained if", a_if_resp_valid, 1'b0);

      // LAT=3: three back-to-back stores, then a single load latency probe
      b_issue(1'b1, 32'h0, 32'h11111111); @(negedge clk);
      b_issue(1'b1, 32'h4, 32'h22222222); @(negedge clk);
      b_issue(1'b1, 32'h8, 32'h33333333); @(negedge clk);
      b_ma_req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk1("b idle", b_ma_resp_valid, 1'b0);
      b_issue(1'b0, 32'h4, 32'h0);
      @(negedge clk);
      b_ma_req_valid = 1'b0;
      chk1("b lat c1", b_ma_resp_valid, 1'b0);
      @(negedge clk);
      chk1("b lat c2", b_ma_resp_valid, 1'b0);
      @(negedge clk);
      chk1("b lat c3", b_ma_resp_valid, 1'b1);
      chk32("b lat data", b_ma_rdata, 32'h22222222);
      @(negedge clk);
      chk1("b lat c4", b_ma_resp_valid, 1'b0);

      // LAT=3 backpressure: fill the pipe, stall five cycles, then drain in order
      b_ma_resp_ready = 1'b0;
      b_issue(1'b0, 32'h0, 32'h0); @(negedge clk);
      b_issue(1'b0, 32'h4, 32'h0); @(negedge clk);
      b_issue(1'b0, 32'h8, 32'h0); @(negedge clk);
      b_ma_req_valid = 1'b0;
      for (int s = 0; s < 5; s++) begin
         if (s > 0) @(negedge clk);
         chk1($sformatf("bp%0d ready", s), b_ma_req_ready, 1'b0);
         chk1($sformatf("bp%0d valid", s), b_ma_resp_valid, 1'b1);
         chk32($sformatf("bp%0d data", s), b_ma_rdata, 32'h11111111);
      end
      b_ma_resp_ready = 1'b1;
      @(negedge clk);
      chk1("bp drain2 valid", b_ma_resp_valid, 1'b1);
      chk32("bp drain2 data", b_ma_rdata, 32'h22222222);
      @(negedge clk);
      chk1("bp drain3 valid", b_ma_resp_valid, 1'b1);
      chk32("bp drain3 data", b_ma_rdata, 32'h33333333);
      @(negedge clk);
      chk1("bp empty", b_ma_resp_valid, 1'b0);
      chk1("bp ready", b_ma_req_ready, 1'b1);

      // RV64 instance: doubleword store and sub-word loads
      c_tx("sd", 1'b1, 2'd3, 1'b0, 64'h8, 64'h0123456789ABCDEF, 64'h0);
      c_tx("lw c", 1'b0, 2'd2, 1'b0, 64'hC, 64'h0, 64'h0000000001234567);
      c_tx("lw 8", 1'b0, 2'd2, 1'b0, 64'h8, 64'h0, 64'hFFFFFFFF89ABCDEF);
      c_tx("lwu 8", 1'b0, 2'd2, 1'b1, 64'h8, 64'h0, 64'h0000000089ABCDEF);
      c_tx("ld 8", 1'b0, 2'd3, 1'b0, 64'h8, 64'h0, 64'h0123456789ABCDEF);
      c_tx("lb f", 1'b0, 2'd0, 1'b0, 64'hF, 64'h0, 64'h0000000000000001);

      // reset with responses in flight; a store accepted just before reset must persist
      c_ma_resp_ready = 1'b0;
      c_ma_we = 1'b0; c_ma_size = 2'd3; c_ma_addr = 64'h8; c_ma_req_valid = 1'b1;
      b_issue(1'b0, 32'h0, 32'h0);
      a_ma_we = 1'b1; a_ma_size = 2'd2; a_ma_addr = 32'h80; a_ma_wdata = 32'h55AA55AA; a_ma_req_valid = 1'b1;
      @(negedge clk);
      c_ma_req_valid = 1'b0; b_ma_req_valid = 1'b0; a_ma_req_valid = 1'b0;
      chk1("c held pre-rst", c_ma_resp_valid, 1'b1);
      rst = 1'b1;
      #1;
      chk1("in-rst c valid", c_ma_resp_valid, 1'b0);
      chk64("in-rst c rdata", c_ma_rdata, 64'h0);
      chk1("in-rst a valid", a_ma_resp_valid, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      c_ma_resp_ready = 1'b1;
      chk1("rel c ready", c_ma_req_ready, 1'b1);
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         chk1($sformatf("rel%0d b valid", s), b_ma_resp_valid, 1'b0);
         chk1($sformatf("rel%0d c valid", s), c_ma_resp_valid, 1'b0);
      end
      a_ma_we = 1'b0; a_ma_addr = 32'h80; a_ma_req_valid = 1'b1;
      @(negedge clk);
      a_ma_req_valid = 1'b0;
      chk1("persist valid", a_ma_resp_valid, 1'b1);
      chk32("persist a", a_ma_rdata, 32'h55AA55AA);
      c_tx("persist c", 1'b0, 2'd3, 1'b0, 64'h8, 64'h0, 64'h0123456789ABCDEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
